// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the execute-stage multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// md_div_core: iterative unsigned restoring divider, one quotient bit per cycle.
module md_div_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [WIDTH:0]   trial, diff;

    always_comb begin
        trial  = {rem_q, quo_q[WIDTH-1]};
        diff   = trial - {1'b0, dvs_q};
        done   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (start && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
        end else if (busy_q) begin
            // diff[WIDTH] set means the trial subtraction borrowed: restore
            quo_d  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            rem_d  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            cnt_d  = cnt_q + 1'b1;
            busy_d = !done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy      = busy_q;
    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: execute-stage multiply/divide unit owning the HI/LO registers.
module exe_muldiv
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MdStartE,
    input  logic [2:0]       MdOpE,
    input  logic             MdReadE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic [WIDTH-1:0] HiE,
    output logic [WIDTH-1:0] LoE,
    output logic             BusyE,
    output logic             StallE
);
    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] ma_q, ma_d, mb_q, mb_d, prod;
    logic               sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
    logic               is_sdiv, div_go, div_busy, div_done;
    logic [WIDTH-1:0]   a_abs, b_abs, div_quo, div_rem;

    md_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_go),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        is_sdiv = MdOpE == MD_DIV;
        a_abs   = (is_sdiv && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        b_abs   = (is_sdiv && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
        div_go  = (state_q == IDLE) && MdStartE && (MdOpE == MD_DIV || MdOpE == MD_DIVU);
        prod    = ma_q * mb_q;
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        dz_d    = dz_q;
        if (state_q == IDLE && MdStartE) begin
            case (MdOpE)
                MD_MULT, MD_MULTU: begin
                    // MD_MULT is even, MD_MULTU odd: bit 0 selects zero extension
                    ma_d    = {{WIDTH{SrcAE[WIDTH-1] & ~MdOpE[0]}}, SrcAE};
                    mb_d    = {{WIDTH{SrcBE[WIDTH-1] & ~MdOpE[0]}}, SrcBE};
                    state_d = MUL;
                end
                MD_DIV, MD_DIVU: begin
                    sq_d    = is_sdiv & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                    sr_d    = is_sdiv & SrcAE[WIDTH-1];
                    dz_d    = SrcBE == '0;
                    state_d = DIV;
                end
                MD_MTHI: hi_d = SrcAE;
                MD_MTLO: lo_d = SrcAE;
                default: ;
            endcase
        end else if (state_q == MUL) begin
            {hi_d, lo_d} = prod;
            state_d      = IDLE;
        end else if (state_q == DIV && div_done) begin
            lo_d    = (sq_q && !dz_q) ? -div_quo : div_quo;
            hi_d    = (sr_q && !dz_q) ? -div_rem : div_rem;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            dz_q    <= dz_d;
        end
    end

    // the divider is busy exactly while the FSM sits in DIV
    assign BusyE  = (state_q == MUL) | div_busy;
    assign StallE = BusyE & (MdStartE | MdReadE);
    assign HiE    = hi_q;
    assign LoE    = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed vectors with a cycle-tagged scoreboard for exe_muldiv.
module tb_exe_muldiv;
    import md_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, MdStartE = 1'b0, MdReadE = 1'b0;
    logic [2:0]  MdOpE = 3'd0;
    logic [31:0] SrcAE = '0, SrcBE = '0, HiE, LoE;
    logic        BusyE, StallE;

    exe_muldiv dut (
        .clk(clk), .rst_n(rst_n), .MdStartE(MdStartE), .MdOpE(MdOpE), .MdReadE(MdReadE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .HiE(HiE), .LoE(LoE), .BusyE(BusyE), .StallE(StallE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          when;
        logic        busy;
        logic        stall;
        bit          hl;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0, n_pass = 0;

    task automatic expect_at(input int when, input logic busy, input logic stall, input bit hl,
                             input logic [31:0] hi, input logic [31:0] lo, input string name);
        exp_t e;
        e.when = when; e.busy = busy; e.stall = stall; e.hl = hl; e.hi = hi; e.lo = lo; e.name = name;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].when == cyc) begin
                n_chk++;
                if (BusyE === sbq[i].busy && StallE === sbq[i].stall &&
                    (!sbq[i].hl || (HiE === sbq[i].hi && LoE === sbq[i].lo)))
                    n_pass++;
                else
                    $display("FAIL %s @%0d: got busy=%b stall=%b hi=%h lo=%h, want busy=%b stall=%b hi=%h lo=%h",
                             sbq[i].name, cyc, BusyE, StallE, HiE, LoE,
                             sbq[i].busy, sbq[i].stall, sbq[i].hi, sbq[i].lo);
                sbq.delete(i);
            end
        end
    end

    task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        n = cyc; MdOpE = op; SrcAE = a; SrcBE = b; MdStartE = 1'b1;
        @(posedge clk); #1;
        MdStartE = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n, n2;
        @(posedge clk); #1;
        MdStartE = 1'b1; MdOpE = MD_MTHI; SrcAE = 32'hDEAD_BEEF;
        expect_at(cyc, 0, 0, 1, 32'h0, 32'h0, "reset_state");
        @(posedge clk); #1;
        @(posedge clk); #1;
        MdStartE = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        expect_at(cyc, 0, 0, 1, 32'h0, 32'h0, "after_reset");
        @(posedge clk); #1;

        go(MD_DIVU, 32'd100, 32'd7, n);
        expect_at(n + 1, 1, 0, 1, 32'h0, 32'h0, "divu_busy_first");
        expect_at(n + 5, 1, 1, 1, 32'h0, 32'h0, "divu_read_stall");
        expect_at(n + 32, 1, 0, 1, 32'h0, 32'h0, "divu_busy_last");
        expect_at(n + 33, 0, 0, 1, 32'd2, 32'd14, "divu_100_7");
        wait_to(n + 5);
        MdReadE = 1'b1;
        @(posedge clk); #1;
        MdReadE = 1'b0;
        wait_to(n + 33);
        n_chk++;
        if (HiE === 32'd2 && LoE === 32'd14) n_pass++;
        else $display("FAIL direct_divu_100_7: got hi=%h lo=%h, want hi=2 lo=e", HiE, LoE);

        go(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
        expect_at(n + 1, 1, 0, 1, 32'd2, 32'd14, "div_hold_hilo");
        expect_at(n + 33, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
        wait_to(n + 33);
        n_chk++;
        if (LoE === 32'hFFFF_FFFD) n_pass++;
        else $display("FAIL direct_div_neg7_2: got lo=%h, want lo=fffffffd", LoE);

        go(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        expect_at(n + 33, 0, 0, 1, 32'h0, 32'h8000_0000, "div_overflow");
        wait_to(n + 33);
        n_chk++;
        if (LoE === 32'h8000_0000) n_pass++;
        else $display("FAIL direct_div_overflow: got lo=%h, want lo=80000000", LoE);

        go(MD_MULT, 32'hFFFF_FFFF, 32'd2, n);
        expect_at(n + 1, 1, 0, 1, 32'h0, 32'h8000_0000, "mult_busy_hold");
        expect_at(n + 2, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg1_2");
        wait_to(n + 2);
        n_chk++;
        if (HiE === 32'hFFFF_FFFF) n_pass++;
        else $display("FAIL direct_mult_neg1_2: got hi=%h, want hi=ffffffff", HiE);

        go(MD_MULTU, 32'hFFFF_FFFF, 32'd2, n);
        expect_at(n + 2, 0, 0, 1, 32'h1, 32'hFFFF_FFFE, "multu_ffff_2");
        wait_to(n + 2);

        go(MD_DIVU, 32'h1234, 32'h0, n);
        expect_at(n + 32, 1, 0, 1, 32'h1, 32'hFFFF_FFFE, "divz_busy_last");
        expect_at(n + 33, 0, 0, 1, 32'h1234, 32'hFFFF_FFFF, "divu_by_zero");
        wait_to(n + 33);
        n_chk++;
        if (HiE === 32'h1234) n_pass++;
        else $display("FAIL direct_divu_by_zero: got hi=%h, want hi=00001234", HiE);

        go(MD_MTHI, 32'hA5A5_A5A5, 32'h0, n);
        expect_at(n + 1, 0, 0, 1, 32'hA5A5_A5A5, 32'hFFFF_FFFF, "mthi_nostall");
        go(MD_MTLO, 32'h5A5A_5A5A, 32'h0, n2);
        expect_at(n2 + 1, 0, 0, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, "mtlo_next_edge");

        go(3'd7, 32'h1, 32'h1, n);
        expect_at(n + 1, 0, 0, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, "undef_op_ignored");

        n = cyc; MdOpE = MD_DIVU; SrcAE = 32'd100; SrcBE = 32'd7; MdStartE = 1'b1;
        expect_at(n + 1, 1, 1, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, "held_stall_first");
        expect_at(n + 32, 1, 1, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, "held_stall_last");
        expect_at(n + 33, 0, 0, 1, 32'd2, 32'd14, "held_div_done");
        expect_at(n + 34, 1, 0, 1, 32'd2, 32'd14, "held_mul_busy");
        expect_at(n + 35, 0, 0, 1, 32'd0, 32'd15, "held_mul_result");
        @(posedge clk); #1;
        MdOpE = MD_MULTU; SrcAE = 32'd3; SrcBE = 32'd5;
        wait_to(n + 34);
        MdStartE = 1'b0;
        wait_to(n + 35);

        go(MD_DIVU, 32'd1000, 32'd3, n);
        expect_at(n + 9, 1, 0, 1, 32'd0, 32'd15, "pre_reset_busy");
        wait_to(n + 10);
        MdReadE = 1'b1; rst_n = 1'b0;
        expect_at(n + 10, 0, 0, 1, 32'h0, 32'h0, "async_reset_mid_div");
        @(posedge clk); #1;
        rst_n = 1'b1; MdReadE = 1'b0;
        go(MD_DIVU, 32'd9, 32'd3, n);
        expect_at(n + 1, 1, 0, 1, 32'h0, 32'h0, "divu_9_3_busy");
        expect_at(n + 33, 0, 0, 1, 32'h0, 32'd3, "divu_9_3");
        wait_to(n + 35);

        foreach (sbq[i]) begin
            n_chk++;
            $display("FAIL %s: expectation for cycle %0d never compared, want compared", sbq[i].name, sbq[i].when);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- Execute-stage multiply/divide unit that sits beside the ALU, upstream of the EX/MEM pipeline register.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- MFHI/MFLO results reach ALUOutE through the datapath mux. StallE freezes the fetch, decode and execute stages while a divide is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- MdStartE  in  1  MD instruction valid in EX this cycle
- MdOpE  in  3  operation code (encodings in package)
- MdReadE  in  1  MFHI/MFLO in EX this cycle
- SrcAE  in  WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO data)
- SrcBE  in  WIDTH  rt operand (divisor, multiplier)
- HiE  out  WIDTH  current HI
- LoE  out  WIDTH  current LO
- BusyE  out  1  unit busy (state != IDLE)
- StallE  out  1  pipeline stall request

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, HI=0, LO=0, counter=0, all internal operand and remainder registers=0, BusyE=0, StallE=0.
- StallE is combinational: StallE = BusyE & (MdStartE | MdReadE). Upstream holds the instruction while stalled.
- Start is accepted only when state=IDLE and MdStartE=1. A start while busy is ignored; the stall keeps it presented.
- FSM states: IDLE, MUL, DIV.
- IDLE transitions:
  - MTHI: HI<=SrcAE at the edge; stays IDLE; 0 busy cycles.
  - MTLO: LO<=SrcAE at the edge; stays IDLE; 0 busy cycles.
  - MULT/MULTU: latch operands (signed or unsigned extension to 2*WIDTH); go to MUL.
  - DIV/DIVU: latch |A|, |B| (unsigned ops take operands raw); record sign_q = A[msb]^B[msb] and sign_r = A[msb] for DIV only; clear the remainder register; counter<=0; go to DIV.
  - Undefined MdOpE with MdStartE: ignored; stays IDLE.
- MUL: one cycle. {HI,LO} <= 2*WIDTH product (signed for MULT); return to IDLE.
- DIV: restoring radix-2, one quotient bit per cycle, WIDTH cycles.
  - On the last iteration (counter=WIDTH-1) write LO=quotient and HI=remainder, applying two's-complement negation per sign_q/sign_r when signed; return to IDLE.
- Latency, start accepted in cycle N:
  - MULT: BusyE high in N+1; HI/LO new from N+2.
  - DIV: BusyE high N+1..N+WIDTH; HI/LO new from N+WIDTH+1.
- MdReadE in cycle N+1 after a start in N stalls; HiE/LoE are never forwarded mid-operation.
- Divide by zero (SrcBE=0): full WIDTH cycles; result HI=SrcAE (as latched), LO=all ones. Bypass any sign fixup.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the unsigned core and negation.
- HiE/LoE hold their previous values throughout MUL/DIV; there is no partial update.
- Reset mid-operation: immediately returns to IDLE, HI/LO=0, BusyE and StallE deassert asynchronously.

Decomposition:
- Package md_pkg holds:
  - MdOp encodings: MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
  - State encodings IDLE, MUL, DIV.
- One sub-module, md_div_core, holds the iterative unsigned restoring divider: start, busy, done, quotient, remainder, its own counter, and the same clk/rst_n.
- Sign handling, the multiplier, the FSM and HI/LO stay in the top module.

Test Plan:
- DIVU 100/7 at cycle 0 -> BusyE=1 in cycles 1..32; LO=14, HI=2 from cycle 33; MdReadE in cycle 5 gives StallE=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT 0xFFFFFFFF × 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE at cycle 2; MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIVU 0x1234 / 0 -> HI=0x00001234, LO=0xFFFFFFFF after 32 busy cycles.
- Back-to-back: MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A -> HI/LO update at consecutive edges with no stall; DIV started with MdStartE held -> second start accepted only on the first IDLE cycle.
- rst_n pulsed low at cycle 10 of a DIV -> BusyE=0, StallE=0, HI=LO=0 asynchronously; a new DIVU 9/3 then gives LO=3, HI=0.
